// File: rtl/dht11_uart_pkg.sv
// Shared types and constants for the DHT11 reading-to-UART text formatter.
package dht11_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  localparam logic [7:0] ASC_H     = 8'h48;
  localparam logic [7:0] ASC_T     = 8'h54;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_ZERO  = 8'h30;

  localparam int MSG_LEN_CRLF   = 13;
  localparam int MSG_LEN_NOCRLF = 11;

  // Shift-add-3 steps for an 8-bit binary input.
  localparam int BCD_STEPS = 8;

  // WAIT_ACK clocks allowed for send_busy to rise before the byte is re-issued.
  localparam logic [2:0] ACK_TIMEOUT = 3'd4;

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
    return ASC_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/dht11_uart_fmt_bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// The start cycle performs the first shift, so the result is ready 8 clocks after start.
module bin2bcd8
  import dht11_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  // acc = {hundreds, tens, units, remaining binary bits}
  logic [19:0] acc_q, acc_d;
  logic [19:0] step_in, adj;
  logic [2:0]  cnt_q, cnt_d;
  logic        run_q, run_d;

  assign done = run_q && (cnt_q == 3'(BCD_STEPS - 1));
  assign bcd  = acc_q[19:8];

  always_comb begin
    step_in = start ? {12'd0, bin} : acc_q;
    adj     = step_in;
    for (int i = 0; i < 3; i++) begin
      if (step_in[8 + 4*i +: 4] >= 4'd5) begin
        adj[8 + 4*i +: 4] = step_in[8 + 4*i +: 4] + 4'd3;
      end
    end

    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      acc_d = adj << 1;
      cnt_d = 3'd1;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = adj << 1;
      cnt_d = cnt_q + 3'd1;
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/dht11_uart_fmt.sv
// Formats each humidity/temperature reading as "H:ddd T:ddd[\r\n]" and hands it
// byte by byte to a UART transmitter over a send_en / send_busy handshake.
module dht11_uart_fmt
  import dht11_uart_pkg::*;
#(
  parameter int CRLF_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [7:0] hum_int,
  input  logic [7:0] temp_int,
  output logic       send_en,
  output logic [7:0] send_data,
  input  logic       send_busy,
  output logic       fmt_busy
);

  localparam logic [3:0] LAST_IDX = (CRLF_EN != 0) ? 4'(MSG_LEN_CRLF - 1)
                                                   : 4'(MSG_LEN_NOCRLF - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  ack_cnt_q, ack_cnt_d;
  logic        send_en_q, send_en_d;
  logic [7:0]  send_data_q, send_data_d;
  logic [7:0]  hum_q, hum_d;
  logic [7:0]  temp_q, temp_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  pend_hum_q, pend_hum_d;
  logic [7:0]  pend_temp_q, pend_temp_d;
  logic        bcd_start_q, bcd_start_d;

  logic [11:0] hum_bcd, temp_bcd;
  logic        hum_done, temp_done;
  logic [7:0]  byte_sel;

  bin2bcd8 u_hum_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start_q),
    .bin   (hum_q),
    .bcd   (hum_bcd),
    .done  (hum_done)
  );

  bin2bcd8 u_temp_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start_q),
    .bin   (temp_q),
    .bcd   (temp_bcd),
    .done  (temp_done)
  );

  assign send_en   = send_en_q;
  assign send_data = send_data_q;
  assign fmt_busy  = (state_q != IDLE);

  always_comb begin
    byte_sel = 8'h00;
    case (idx_q)
      4'd0:    byte_sel = ASC_H;
      4'd1:    byte_sel = ASC_COLON;
      4'd2:    byte_sel = bcd_to_ascii(hum_bcd[11:8]);
      4'd3:    byte_sel = bcd_to_ascii(hum_bcd[7:4]);
      4'd4:    byte_sel = bcd_to_ascii(hum_bcd[3:0]);
      4'd5:    byte_sel = ASC_SPACE;
      4'd6:    byte_sel = ASC_T;
      4'd7:    byte_sel = ASC_COLON;
      4'd8:    byte_sel = bcd_to_ascii(temp_bcd[11:8]);
      4'd9:    byte_sel = bcd_to_ascii(temp_bcd[7:4]);
      4'd10:   byte_sel = bcd_to_ascii(temp_bcd[3:0]);
      4'd11:   byte_sel = ASC_CR;
      4'd12:   byte_sel = ASC_LF;
      default: byte_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ack_cnt_d   = ack_cnt_q;
    send_en_d   = 1'b0;
    send_data_d = send_data_q;
    hum_d       = hum_q;
    temp_d      = temp_q;
    pend_vld_d  = pend_vld_q;
    pend_hum_d  = pend_hum_q;
    pend_temp_d = pend_temp_q;
    bcd_start_d = 1'b0;

    // Readings arriving mid-message park here; the newest one wins.
    if (data_valid && (state_q != IDLE)) begin
      pend_vld_d  = 1'b1;
      pend_hum_d  = hum_int;
      pend_temp_d = temp_int;
    end

    case (state_q)
      IDLE: begin
        if (data_valid) begin
          hum_d       = hum_int;
          temp_d      = temp_int;
          bcd_start_d = 1'b1;
          state_d     = CONV;
        end
      end
      CONV: begin
        if (hum_done && temp_done) begin
          idx_d   = 4'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!send_busy) begin
          send_en_d   = 1'b1;
          send_data_d = byte_sel;
          ack_cnt_d   = 3'd0;
          state_d     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // The first WAIT_ACK clock is the send_en cycle itself, so a timeout
        // re-issues the byte six clocks after the previous pulse.
        if (send_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == ACK_TIMEOUT) begin
          state_d = ISSUE;
        end else begin
          ack_cnt_d = ack_cnt_q + 3'd1;
        end
      end
      WAIT_DONE: begin
        if (!send_busy) begin
          if (idx_q == LAST_IDX) begin
            idx_d = 4'd0;
            if (data_valid) begin
              hum_d       = hum_int;
              temp_d      = temp_int;
              pend_vld_d  = 1'b0;
              bcd_start_d = 1'b1;
              state_d     = CONV;
            end else if (pend_vld_q) begin
              hum_d       = pend_hum_q;
              temp_d      = pend_temp_q;
              pend_vld_d  = 1'b0;
              bcd_start_d = 1'b1;
              state_d     = CONV;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ack_cnt_q   <= '0;
      send_en_q   <= 1'b0;
      send_data_q <= 8'h00;
      hum_q       <= '0;
      temp_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_hum_q  <= '0;
      pend_temp_q <= '0;
      bcd_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ack_cnt_q   <= ack_cnt_d;
      send_en_q   <= send_en_d;
      send_data_q <= send_data_d;
      hum_q       <= hum_d;
      temp_q      <= temp_d;
      pend_vld_q  <= pend_vld_d;
      pend_hum_q  <= pend_hum_d;
      pend_temp_q <= pend_temp_d;
      bcd_start_q <= bcd_start_d;
    end
  end

endmodule

// File: tb/tb_dht11_uart_fmt.sv
// Scoreboard bench for dht11_uart_fmt: CRLF and no-CRLF instances share one
// behavioural UART transmitter; only one instance is active at a time.
module tb_dht11_uart_fmt;

  logic       clk, rst;
  logic       dv0, dv1;
  logic [7:0] hum, temp;
  logic       send_en0, send_en1, fmt_busy0, fmt_busy1;
  logic [7:0] send_data0, send_data1;
  logic       tx_busy, force_busy, tx_on;
  logic       send_busy;
  int         frame_clks;
  int         cyc;
  int         t_strobe;
  int         n_cmp, n_fail;
  logic [7:0] exp_q[$];
  int         en_cyc_q[$];
  logic       prev0, prev1;
  logic [7:0] mon_got, mon_exp;

  assign send_busy = tx_busy | force_busy;

  dht11_uart_fmt #(.CRLF_EN(1)) dut0 (
    .clk(clk), .rst(rst), .data_valid(dv0), .hum_int(hum), .temp_int(temp),
    .send_en(send_en0), .send_data(send_data0), .send_busy(send_busy), .fmt_busy(fmt_busy0)
  );

  dht11_uart_fmt #(.CRLF_EN(0)) dut1 (
    .clk(clk), .rst(rst), .data_valid(dv1), .hum_int(hum), .temp_int(temp),
    .send_en(send_en1), .send_data(send_data1), .send_busy(send_busy), .fmt_busy(fmt_busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the text line for a reading, straight from its decimal digits.
  task automatic push_num(input int v);
    exp_q.push_back(8'(48 + v / 100));
    exp_q.push_back(8'(48 + (v / 10) % 10));
    exp_q.push_back(8'(48 + v % 10));
  endtask

  task automatic push_msg(input int h, input int t, input bit crlf);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h3A);
    push_num(h);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h3A);
    push_num(t);
    if (crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // UART model: busy rises the clock after an accepted send_en, lasts frame_clks.
  initial begin
    int   left;
    logic en_s;
    tx_busy = 1'b0;
    left    = 0;
    forever begin
      @(negedge clk);
      en_s = send_en0 | send_en1;
      @(posedge clk);
      #1;
      if (left > 0) begin
        left--;
        if (left == 0) tx_busy = 1'b0;
      end
      if (en_s && tx_on) begin
        tx_busy = 1'b1;
        left    = frame_clks;
      end
    end
  end

  // Monitor: every send_en pulse is checked against the head of the expected queue.
  initial begin
    prev0 = 1'b0;
    prev1 = 1'b0;
    forever begin
      @(negedge clk);
      if (send_en0 || send_en1) begin
        mon_got = send_en0 ? send_data0 : send_data1;
        en_cyc_q.push_back(cyc);
        chk("en_exclusive", int'(send_en0 && send_en1), 0);
        chk("no_back_to_back", int'((send_en0 && prev0) || (send_en1 && prev1)), 0);
        chk("en_while_busy", int'(send_busy), 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%02h, expected no byte (cycle %0d)", mon_got, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("byte", int'(mon_got), int'(mon_exp));
        end
      end
      prev0 = send_en0;
      prev1 = send_en1;
    end
  end

  // Caller is positioned at a negedge.
  task automatic strobe(input int d, input int h, input int t);
    hum  = 8'(h);
    temp = 8'(t);
    if (d == 0) dv0 = 1'b1;
    else        dv1 = 1'b1;
    t_strobe = cyc;
    @(negedge clk);
    dv0 = 1'b0;
    dv1 = 1'b0;
  endtask

  task automatic wait_en(input int n, input int budget);
    int k;
    k = 0;
    while (en_cyc_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("pulse_count_reached", int'(en_cyc_q.size() >= n), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((fmt_busy0 || fmt_busy1 || send_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", int'(fmt_busy0 || fmt_busy1 || send_busy), 0);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic run_msg(input int d, input int h, input int t);
    int base;
    base = en_cyc_q.size();
    push_msg(h, t, d == 0);
    strobe(d, h, t);
    wait_en(base + 1, 40);
    if (en_cyc_q.size() > base) chk("first_latency", en_cyc_q[base] - t_strobe, 10);
    wait_idle(2000);
    chk("msg_len", en_cyc_q.size() - base, (d == 0) ? 13 : 11);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion within 40000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    int h, t, d;
    int edge_h[3] = '{7, 99, 9};
    int edge_t[3] = '{255, 100, 199};
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; dv0 = 1'b0; dv1 = 1'b0; hum = '0; temp = '0;
    force_busy = 1'b0; tx_on = 1'b1; frame_clks = 8; t_strobe = 0;

    repeat (3) @(negedge clk);
    chk("rst_send_en0", int'(send_en0), 0);
    chk("rst_send_data0", int'(send_data0), 0);
    chk("rst_fmt_busy0", int'(fmt_busy0), 0);
    chk("rst_send_en1", int'(send_en1), 0);
    chk("rst_send_data1", int'(send_data1), 0);
    chk("rst_fmt_busy1", int'(fmt_busy1), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic messages with and without CRLF.
    run_msg(0, 45, 23);
    run_msg(1, 0, 255);
    for (int i = 0; i < 3; i++) run_msg(i % 2, edge_h[i], edge_t[i]);

    for (int r = 0; r < 14; r++) begin
      d = int'($urandom_range(0, 1));
      h = int'($urandom_range(0, 255));
      t = int'($urandom_range(0, 255));
      frame_clks = int'($urandom_range(2, 20));
      run_msg(d, h, t);
    end
    frame_clks = 8;

    // Two strobes during byte 3: only the latest follows the current message.
    base = en_cyc_q.size();
    push_msg(10, 20, 1);
    push_msg(50, 60, 1);
    strobe(0, 10, 20);
    wait_en(base + 4, 200);
    strobe(0, 30, 40);
    @(negedge clk);
    strobe(0, 50, 60);
    wait_idle(3000);
    chk("pending_len", en_cyc_q.size() - base, 26);

    // Strobe in the completion cycle supersedes an earlier pending reading.
    base = en_cyc_q.size();
    push_msg(11, 22, 1);
    push_msg(33, 44, 1);
    strobe(0, 11, 22);
    wait_en(base + 6, 200);
    strobe(0, 88, 77);
    wait_en(base + 13, 400);
    k = 0;
    while (!tx_busy && k < 50) begin @(negedge clk); k++; end
    while (tx_busy && k < 100) begin @(negedge clk); k++; end
    chk("boundary_sync", int'(tx_busy), 0);
    strobe(0, 33, 44);
    wait_en(base + 14, 40);
    if (en_cyc_q.size() > base + 13) chk("boundary_latency", en_cyc_q[base + 13] - t_strobe, 10);
    wait_idle(3000);
    chk("boundary_len", en_cyc_q.size() - base, 26);

    // Reset during byte 6 with a reading pending: message and pending both dropped.
    base = en_cyc_q.size();
    push_msg(12, 34, 1);
    strobe(0, 12, 34);
    wait_en(base + 6, 200);
    strobe(0, 77, 88);
    wait_en(base + 7, 200);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_send_en", int'(send_en0), 0);
    chk("rst_mid_fmt_busy", int'(fmt_busy0), 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (40) @(negedge clk);
    chk("no_send_after_rst", en_cyc_q.size() - base, 7);
    chk("idle_after_rst", int'(fmt_busy0), 0);
    run_msg(0, 99, 1);

    // Busy held high through ISSUE: nothing until release, then a single pulse.
    base = en_cyc_q.size();
    push_msg(5, 6, 1);
    force_busy = 1'b1;
    strobe(0, 5, 6);
    repeat (50) @(negedge clk);
    chk("held_no_en", en_cyc_q.size() - base, 0);
    force_busy = 1'b0;
    t_strobe = cyc;
    wait_en(base + 1, 10);
    if (en_cyc_q.size() > base) chk("release_latency", en_cyc_q[base] - t_strobe, 1);
    repeat (5) @(negedge clk);
    chk("single_pulse", en_cyc_q.size() - base, 1);
    wait_idle(2000);
    chk("held_len", en_cyc_q.size() - base, 13);

    // Busy never rises: byte 0 re-issued every 6 clocks.
    tx_on = 1'b0;
    base = en_cyc_q.size();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h48);
    strobe(0, 1, 2);
    wait_en(base + 4, 100);
    if (en_cyc_q.size() >= base + 4) begin
      chk("retry_first_latency", en_cyc_q[base] - t_strobe, 10);
      for (int i = 1; i < 4; i++) chk("retry_period", en_cyc_q[base + i] - en_cyc_q[base + i - 1], 6);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_on = 1'b1;
    repeat (10) @(negedge clk);
    chk("retry_drain", exp_q.size(), 0);
    chk("retry_pulses", en_cyc_q.size() - base, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dht11_uart_fmt.md
DHT11_UART_FMT -- requirements
Module: dht11_uart_fmt

Interface
REQ-001 SHALL have parameter CRLF_EN, default 1, meaning: 1 appends "\r\n" to each message, 0 omits it.
REQ-002 SHALL have port clk  input  1  the single system clock; all logic is synchronous to its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port data_valid  input  1  one-cycle strobe: a new reading is present on hum_int/temp_int.
REQ-005 SHALL have port hum_int  input  8  humidity integer part, 0-255.
REQ-006 SHALL have port temp_int  input  8  temperature integer part, 0-255.
REQ-007 SHALL have port send_en  output  1  one-cycle request to the downstream UART transmitter to send one byte.
REQ-008 SHALL have port send_data  output  8  byte to send; valid in the cycle send_en is high.
REQ-009 SHALL have port send_busy  input  1  downstream transmitter busy; rises the cycle after send_en is accepted and falls after the stop bit.
REQ-010 SHALL have port fmt_busy  output  1  high whenever the block is not in IDLE.

Function
REQ-011 SHALL emit the ASCII message "H:" d2 d1 d0 " T:" d2 d1 d0, followed by 0x0D 0x0A when CRLF_EN=1: 13 bytes with CRLF, 11 without.
REQ-012 SHALL render each value as exactly three decimal digits with leading zeros (e.g. 7 -> "007", 255 -> "255"), each digit being 0x30 + its BCD value.
REQ-013 SHALL use states IDLE, CONV, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-014 IDLE: on data_valid, SHALL capture hum_int and temp_int into working registers and go to CONV.
REQ-015 CONV: SHALL run both binary-to-BCD conversions in parallel for exactly 8 clocks, then go to ISSUE with the byte index at 0.
REQ-016 ISSUE: when send_busy=0, SHALL drive send_en=1 for exactly one cycle with send_data set to the byte at the current index, then go to WAIT_ACK.
REQ-017 ISSUE: while send_busy=1, SHALL hold send_en=0 and remain in ISSUE.
REQ-018 WAIT_ACK: SHALL wait for send_busy=1 and then go to WAIT_DONE.
REQ-019 WAIT_ACK timeout: if send_busy has not risen within 4 clocks, SHALL return to ISSUE and resend the same byte.
REQ-020 WAIT_DONE: when send_busy=0 on the last byte, SHALL go to IDLE, or to CONV if a reading is pending (REQ-021).
REQ-021 WAIT_DONE: when send_busy=0 on any other byte, SHALL increment the byte index and go to ISSUE.
REQ-022 Pending buffer: a data_valid outside IDLE SHALL store the reading in a one-deep pending register; a newer strobe overwrites it (latest wins).
REQ-023 On message completion with a reading pending, SHALL load that reading into the working registers, clear the pending flag and go to CONV.
REQ-024 Pending buffer boundary: a data_valid in the same cycle as message completion SHALL be treated as the pending reading for that completion.
REQ-025 SHALL never assert send_en in two consecutive cycles.
REQ-026 SHALL never assert send_en while send_busy=1.
REQ-027 Latency: first send_en SHALL occur 10 clocks after the data_valid cycle when send_busy=0 (1 capture + 8 CONV + 1 ISSUE).

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, send_en=0, send_data=0x00, fmt_busy=0, pending flag=0, byte index=0 and the BCD registers to 0.
REQ-029 Reset asserted mid-message SHALL abort the message with no further send_en; the pending reading is discarded.

Structure
REQ-030 A shared package dht11_uart_pkg SHALL hold the state enum, the ASCII constants ('H', 'T', ':', ' ', CR, LF, '0') and MSG_LEN_CRLF=13 / MSG_LEN_NOCRLF=11.
REQ-031 SHALL instantiate sub-module bin2bcd8 twice: start strobe, 8-bit input, 8-cycle shift-add-3 (double-dabble), 12-bit BCD output, done strobe.
REQ-032 Byte selection SHALL be a combinational mux indexed by the 4-bit byte index.

Verification
REQ-033 Scenario 1: hum=45, temp=23, send_busy modelled as a 115200-baud TX -> bytes "H:045 T:023\r\n", exactly 13 send_en pulses.
REQ-034 Scenario 2: hum=0, temp=255, CRLF_EN=0 -> "H:000 T:255", 11 bytes, then fmt_busy=0.
REQ-035 Scenario 3: data_valid (10,20) at t=0, (30,40) and then (50,60) during byte 3 -> message for (10,20) then for (50,60), with (30,40) never sent.
REQ-036 Scenario 4: rst pulsed during byte 6 -> send_en stays 0 and fmt_busy=0 within 1 clock; a following data_valid (99,1) yields a complete "H:099 T:001\r\n".
REQ-037 Scenario 5: send_busy held 1 for 50 clocks at ISSUE -> no send_en until it falls, then exactly one pulse.
REQ-038 Scenario 6: send_busy tied 0 -> the same byte is re-issued every 6 clocks, never two adjacent pulses, and the byte index never advances.
